// File: rtl/wptr_ctrl_sync.sv
// Write-side pointer controller for the async FIFO: synchronises the read Gray
// pointer, owns the binary/Gray write pointer, full, fill level, almost-full and sticky overflow.
module wptr_ctrl_sync #(
    parameter int ADDR_WIDTH  = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic                  clr_ovf,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  overflow
);

    localparam int A = ADDR_WIDTH;

    logic [A:0] sync_q [SYNC_STAGES];
    logic [A:0] rq_gray;
    logic [A:0] rq_bin;

    logic [A:0] bin_q,   bin_d;
    logic [A:0] gray_q,  gray_d;
    logic [A:0] level_q, level_d;
    logic       full_q,  full_d;
    logic       af_q,    af_d;
    logic       ovf_q,   ovf_d;

    // Only the first synchroniser stage ever samples the asynchronous read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rq_gray = sync_q[SYNC_STAGES-1];

    always_comb begin
        rq_bin = '0;
        for (int i = 0; i <= A; i++) begin
            rq_bin[i] = ^(rq_gray >> i);
        end
    end

    assign wen = winc & ~full_q;

    // Full compares against the read pointer with its top two Gray bits inverted,
    // i.e. exactly one lap (DEPTH entries) ahead.
    always_comb begin
        bin_d   = bin_q + {{A{1'b0}}, wen};
        gray_d  = (bin_d >> 1) ^ bin_d;
        full_d  = (gray_d == {~rq_gray[A:A-1], rq_gray[A-2:0]});
        level_d = bin_d - rq_bin;
        af_d    = (level_d >= af_thresh);
        ovf_d   = (winc & full_q) | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q   <= '0;
            gray_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign waddr       = bin_q[A-1:0];
    assign wptr_gray   = gray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wlevel      = level_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_ctrl_sync.sv
// Directed bench for wptr_ctrl_sync: fill, overflow, almost-full, read release,
// randomised wrap-around stream and mid-fill reset.
module tb_wptr_ctrl_sync;

    localparam int AW = 6;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          winc;
    logic [AW:0]   rptr_gray;
    logic [AW:0]   af_thresh;
    logic          clr_ovf;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr_gray;
    logic          full;
    logic          almost_full;
    logic [AW:0]   wlevel;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    wptr_ctrl_sync #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .winc(winc), .rptr_gray(rptr_gray),
        .af_thresh(af_thresh), .clr_ovf(clr_ovf), .wen(wen), .waddr(waddr),
        .wptr_gray(wptr_gray), .full(full), .almost_full(almost_full),
        .wlevel(wlevel), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [AW:0] b2g(input logic [AW:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [AW:0] g2b(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; winc = 1'b0; clr_ovf = 1'b0; rptr_gray = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; winc = 1'b1; clr_ovf = 1'b0; rptr_gray = '0; af_thresh = 7'd0;
        #3;
        checks++;
        if ({waddr, wptr_gray, full, almost_full, wlevel, overflow} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got waddr=%0d gray=%h full=%b af=%b lvl=%0d ovf=%b, required all 0",
                     waddr, wptr_gray, full, almost_full, wlevel, overflow);
        end
        checks++;
        if (wen !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_wen: got %b required 1", wen);
        end
        winc = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (almost_full !== 1'b1 || wlevel !== 7'd0) begin
            errors++;
            $display("[TB] FAIL af_thresh_zero: got af=%b lvl=%0d required af=1 lvl=0", almost_full, wlevel);
        end
    endtask

    task automatic test_fill();
        af_thresh = 7'd60;
        do_reset();
        winc = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            #1;
            checks++;
            if (wen !== 1'b1) begin
                errors++;
                $display("[TB] FAIL fill_wen[%0d]: got %b required 1", i, wen);
            end
            tick();
            checks++;
            if (wlevel !== 7'(i) || almost_full !== (i >= 60) || full !== (i == 64)) begin
                errors++;
                $display("[TB] FAIL fill_state[%0d]: got lvl=%0d af=%b full=%b required lvl=%0d af=%b full=%b",
                         i, wlevel, almost_full, full, i, (i >= 60), (i == 64));
            end
        end
        checks++;
        if (waddr !== 6'd0 || wptr_gray !== 7'h60 || wen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_end: got waddr=%0d gray=%h wen=%b required 0 60 0", waddr, wptr_gray, wen);
        end
    endtask

    task automatic test_overflow();
        winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (overflow !== 1'b1 || wptr_gray !== 7'h60 || wen !== 1'b0 || wlevel !== 7'd64) begin
                errors++;
                $display("[TB] FAIL ovf_set[%0d]: got ovf=%b gray=%h wen=%b lvl=%0d required 1 60 0 64",
                         i, overflow, wptr_gray, wen, wlevel);
            end
        end
        clr_ovf = 1'b1;
        tick();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_set_wins: got %b required 1", overflow);
        end
        winc = 1'b0;
        tick();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_clear: got %b required 0", overflow);
        end
        clr_ovf = 1'b0;
    endtask

    task automatic test_read_release();
        winc = 1'b0;
        rptr_gray = 7'h01;
        for (int e = 1; e <= SS + 1; e++) begin
            tick();
            checks++;
            if (full !== (e <= SS)) begin
                errors++;
                $display("[TB] FAIL release_full[edge %0d]: got %b required %b", e, full, (e <= SS));
            end
        end
        checks++;
        if (wlevel !== 7'd63 || almost_full !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_level: got lvl=%0d af=%b required 63 1", wlevel, almost_full);
        end
    endtask

    task automatic test_wrap();
        int          wb, rb, cycles;
        logic [AW:0] s0, s1, lev, oldGray, rqb;
        logic        expFull, wenExp, sawWrap;
        af_thresh = 7'd100;
        do_reset();
        wb = 0; rb = 0; cycles = 0; s0 = '0; s1 = '0; expFull = 1'b0; sawWrap = 1'b0;
        while (wb < 300 && cycles < 4000) begin
            cycles++;
            winc = ($urandom_range(0, 3) != 0);
            wenExp = winc & ~expFull;
            #1;
            checks++;
            if (wen !== wenExp) begin
                errors++;
                $display("[TB] FAIL wrap_wen[cyc %0d]: got %b required %b", cycles, wen, wenExp);
            end
            oldGray = wptr_gray;
            @(posedge clk);
            rqb = g2b(s1);
            if (wenExp) wb++;
            lev = 7'(wb) - rqb;
            expFull = (lev == 7'd64);
            s1 = s0;
            s0 = rptr_gray;
            #1;
            checks++;
            if (wptr_gray !== b2g(7'(wb)) || waddr !== 6'(wb) || wlevel !== lev ||
                full !== expFull || almost_full !== 1'b0) begin
                errors++;
                $display("[TB] FAIL wrap_state[cyc %0d]: got gray=%h waddr=%0d lvl=%0d full=%b af=%b required %h %0d %0d %b 0",
                         cycles, wptr_gray, waddr, wlevel, full, almost_full, b2g(7'(wb)), wb % 64, lev, expFull);
            end
            checks++;
            if ($countones(wptr_gray ^ oldGray) != (wenExp ? 1 : 0)) begin
                errors++;
                $display("[TB] FAIL wrap_gray_step[cyc %0d]: got %h->%h required %0d bit change",
                         cycles, oldGray, wptr_gray, wenExp ? 1 : 0);
            end
            if (oldGray == 7'h40 && wptr_gray == 7'h00) sawWrap = 1'b1;
            if ((wb - rb) > 0 && $urandom_range(0, 2) == 0) rb++;
            rptr_gray = b2g(7'(rb));
        end
        winc = 1'b0;
        checks++;
        if (wb < 300) begin
            errors++;
            $display("[TB] FAIL wrap_timeout: got %0d writes required 300", wb);
        end
        checks++;
        if (!sawWrap) begin
            errors++;
            $display("[TB] FAIL wrap_127_to_0: got no wrap required wrap seen");
        end
    endtask

    task automatic test_reset_mid_fill();
        af_thresh = 7'd60;
        do_reset();
        winc = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (waddr !== 6'd20 || wlevel !== 7'd20) begin
            errors++;
            $display("[TB] FAIL midfill_pre: got waddr=%0d lvl=%0d required 20 20", waddr, wlevel);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({waddr, wptr_gray, full, almost_full, wlevel, overflow} !== '0) begin
            errors++;
            $display("[TB] FAIL midfill_async_reset: got waddr=%0d gray=%h full=%b af=%b lvl=%0d ovf=%b required all 0",
                     waddr, wptr_gray, full, almost_full, wlevel, overflow);
        end
        winc = 1'b0;
        tick();
        rst_n = 1'b1;
        winc = 1'b1;
        #1;
        checks++;
        if (waddr !== 6'd0 || wen !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midfill_first_write: got waddr=%0d wen=%b required 0 1", waddr, wen);
        end
        tick();
        checks++;
        if (waddr !== 6'd1 || wptr_gray !== 7'h01) begin
            errors++;
            $display("[TB] FAIL midfill_after_write: got waddr=%0d gray=%h required 1 01", waddr, wptr_gray);
        end
        winc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_read_release();
        test_wrap();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wptr_ctrl_sync.md
Name: wptr_ctrl_sync

Overview:
- Parametrised next-generation write-side pointer controller for the async FIFO.
- Owns a built-in N-stage synchroniser for the read-domain Gray pointer, the binary/Gray write pointer and a correct full flag.
- Adds a write-domain fill level, a programmable almost-full flag and a sticky overflow error.
- Sits in the write clock domain between the producer interface and the dual-port RAM write port.

Parameters:
- ADDR_WIDTH, 6, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH; legal range >= 2.
- SYNC_STAGES, 2, flop stages in the read-pointer synchroniser; legal range >= 2.

Ports:
- clk  input  1  write-domain clock.
- rst_n  input  1  asynchronous active-low reset.
- winc  input  1  write request from producer.
- rptr_gray  input  ADDR_WIDTH+1  read pointer in Gray code, asynchronous to clk.
- af_thresh  input  ADDR_WIDTH+1  almost-full threshold in entries; quasi-static.
- clr_ovf  input  1  clears the sticky overflow flag.
- wen  output  1  RAM write enable (combinational: winc & ~full).
- waddr  output  ADDR_WIDTH  RAM write address (binary pointer low bits).
- wptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- full  output  1  FIFO full.
- almost_full  output  1  fill level >= af_thresh.
- wlevel  output  ADDR_WIDTH+1  fill level as seen from the write domain, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset: clocks and reset as already decided.
  - Reset is asynchronous, active-low (rst_n).
  - All flops are cleared, including every synchroniser stage.
  - Output values under reset: waddr=0, wptr_gray=0, full=0, almost_full=0, wlevel=0, overflow=0.
  - wen = winc while in reset, since full=0; the producer must not write during reset.
- Synchroniser:
  - rptr_gray passes through SYNC_STAGES flops to give rq_gray.
  - rq_gray is converted Gray-to-binary (XOR prefix from the MSB) to give rq_bin.
  - No other logic samples rptr_gray directly.
- Pointer update:
  - bin_next = bin + wen, with wrap modulo 2**(ADDR_WIDTH+1).
  - gray_next = (bin_next >> 1) ^ bin_next.
  - bin and wptr_gray register bin_next and gray_next on every clk edge.
  - wptr_gray changes by exactly one bit per accepted write, and never glitches since it is a register output.
- Write timing: waddr during the cycle in which wen=1 is the location written. waddr advances at that cycle's closing edge.
- Full:
  - full_next = (gray_next == {~rq_gray[A:A-1], rq_gray[A-2:0]}), where A = ADDR_WIDTH.
  - full is registered.
  - full asserts in the same edge that accepts the DEPTH-th outstanding write.
- Level and almost-full:
  - level_next = bin_next - rq_bin, modulo 2**(A+1). This value is always 0..DEPTH.
  - wlevel and almost_full register level_next and (level_next >= af_thresh).
  - af_thresh=0 makes almost_full=1 permanently (after reset release). af_thresh > DEPTH means it never asserts.
- Level conservatism:
  - wlevel and full are pessimistic: reads become visible after SYNC_STAGES+1 clk edges.
  - Full deassertion is delayed by that amount; writes are never lost.
- Overflow:
  - Set on an edge where winc=1 and full=1.
  - Cleared on an edge where clr_ovf=1.
  - If set and clear occur on the same edge, set wins.
  - A rejected write leaves all pointers unchanged.
- Simultaneous write and read-pointer change: both are applied in the same level_next computation. wlevel is unchanged when one write and one synchronised read coincide.
- Reset mid-operation: everything returns to reset values immediately. The read domain must be reset together with this block.

Test Plan:
- Fill: reset, rptr_gray=0, ADDR_WIDTH=6, winc=1 for 64 cycles.
  - After the 64th accepted edge: full=1, wlevel=64, waddr=0, wptr_gray=7'h60.
  - wen=0 on cycle 65.
- Overflow: from full, winc=1 for 3 cycles.
  - overflow=1, wptr_gray stays 7'h60, wen=0.
  - clr_ovf=1 together with winc=1 keeps overflow=1.
  - clr_ovf=1 alone clears overflow on the next edge.
- Almost-full: af_thresh=60, writes from empty.
  - almost_full=0 through write 59.
  - almost_full=1 at the edge accepting write 60, with wlevel=60.
- Read release: from full, set rptr_gray=7'h01.
  - full stays 1 for SYNC_STAGES edges, then clears on edge SYNC_STAGES+1.
  - wlevel=63 at that point.
- Wrap-around: writer and reader model stream 300 writes at random rates.
  - wptr_gray changes exactly one bit per accepted write.
  - Pointer wraps 127->0.
  - No write is accepted at level 64, and no spurious full.
- Reset mid-fill: assert rst_n=0 after 20 writes.
  - All outputs return to 0 asynchronously.
  - After release, the first write goes to waddr=0.
